// File: rtl/rca_nibble_sequencer.sv
// rtl/rca_nibble_sequencer.sv - multi-cycle WIDTH-bit adder on one shared 4-bit ripple-carry slice
// Optional subtract mode: define RCA_SEQ_SUB_EN to add the sub port.
module rca_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry;
  logic [IDXW-1:0]   idx;

  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [4:0]        slice_res;
  logic              accept;

  assign in_ready = (state == IDLE) & ~rst;
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

  // The one shared ripple-carry slice: operand nibble idx plus the carry from the previous pass.
  always_comb begin
    a_nib     = a_r[idx*4 +: 4];
    b_nib     = b_r[idx*4 +: 4];
    slice_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r <= a;
`ifdef RCA_SEQ_SUB_EN
            // Subtraction as a + ~b + 1; b is stored pre-inverted so the slice stays an adder.
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
`else
            b_r   <= b;
            carry <= cin;
`endif
            idx   <= '0;
            sum   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*4 +: 4] <= slice_res[3:0];
          carry           <= slice_res[4];
          idx             <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout      <= slice_res[4];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// tb/tb_rca_nibble_sequencer.sv - directed self-checking bench for rca_nibble_sequencer
// Define RCA_SEQ_SUB_EN to also exercise subtract mode.
module tb_rca_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;
  int lat;

  always #5 clk = ~clk;

  rca_nibble_sequencer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef RCA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand beat and hold it across exactly one accept edge.
  task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic sv);
    a = av; b = bv; cin = cv; sub = sv;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy_run"}, busy, 1'b1);
    check({tag, "_sum_cleared"}, sum, 16'h0000);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic sv,
                        input logic [15:0] exp_sum, input logic exp_cout);
    start_op(tag, av, bv, cv, sv);
    wait_done(lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    release_result();
    check({tag, "_out_valid_clr"}, out_valid, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

    // Reset held for two cycles, with in_valid asserted to show it is ignored
    in_valid = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    run_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
    run_op("add_ffff", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    run_op("add_1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);

    // Backpressure: hold DONE with in_valid high and new operands waiting
    start_op("bp", 16'hABCD, 16'h1111, 1'b0, 1'b0);
    a = 16'h8000; b = 16'h8000; cin = 1'b1;
    in_valid = 1'b1;
    wait_done(lat);
    check("bp_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_sum", sum, 16'hBCDE);
      check("bp_hold_cout", cout, 1'b0);
      check("bp_hold_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rel_valid", out_valid, 1'b0);
    check("bp_rel_idle", busy, 1'b0);
    check("bp_rel_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_second_accept", busy, 1'b1);
    wait_done(lat);
    check("bp2_latency", lat, 4);
    check("bp2_sum", sum, 16'h0001);
    check("bp2_cout", cout, 1'b1);
    release_result();

    // Reset in the middle of RUN (idx==2)
    start_op("mid", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, 16'h0000);
    check("mid_rst_cout", cout, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    run_op("after_rst", 16'h0008, 16'h0008, 1'b0, 1'b0, 16'h0010, 1'b0);

`ifdef RCA_SEQ_SUB_EN
    run_op("sub_5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_7m5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    run_op("sub_cin_ign", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
